// File: rtl/sseg_capture.sv
// sseg_capture: decodes a scanned four-digit seven-segment bus (an/seg/dp) back into a 16-bit word.
// Define SSEG_CAP_BLANK_EN to accept an all-off glyph as a blank digit instead of an error.
module sseg_capture #(
  parameter int SETTLE = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  an,
  input  logic [6:0]  seg,
  input  logic        dp,
  input  logic        clear,
  output logic [15:0] digits,
  output logic [3:0]  dps,
  output logic        valid,
  output logic        frame_stb,
  output logic        err_seg,
  output logic        err_an
);
  typedef enum logic [1:0] {IDLE, SETTLING, HELD} state_t;
  state_t      state;
  logic [11:0] p;
  logic [7:0]  cnt;
  logic [3:0]  seen, seen_nxt, nib;
  logic [1:0]  idx;
  logic        chg, cap, one, blank_an, known, blank_seg, good;
  always_comb begin
    chg      = {an, seg, dp} != p;
    cap      = !chg && state == SETTLING && cnt == 8'(SETTLE - 1);
    blank_an = p[11:8] == 4'hF;
    one      = $onehot(~p[11:8]);
    idx      = !p[8] ? 2'd0 : !p[9] ? 2'd1 : !p[10] ? 2'd2 : 2'd3;
    known    = 1'b1;
    nib      = 4'h0;
    case (p[7:1])
      7'h40: nib = 4'h0;
      7'h79: nib = 4'h1;
      7'h24: nib = 4'h2;
      7'h30: nib = 4'h3;
      7'h19: nib = 4'h4;
      7'h12: nib = 4'h5;
      7'h02: nib = 4'h6;
      7'h78: nib = 4'h7;
      7'h00: nib = 4'h8;
      7'h10: nib = 4'h9;
      7'h08: nib = 4'hA;
      7'h03: nib = 4'hB;
      7'h46: nib = 4'hC;
      7'h21: nib = 4'hD;
      7'h06: nib = 4'hE;
      7'h0E: nib = 4'hF;
      default: known = 1'b0;
    endcase
`ifdef SSEG_CAP_BLANK_EN
    blank_seg = p[7:1] == 7'h7F;
`else
    blank_seg = 1'b0;
`endif
    good     = cap && one && (known || blank_seg);
    seen_nxt = good ? seen | (4'b0001 << idx) : seen;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      p         <= '1;
      cnt       <= '0;
      seen      <= '0;
      digits    <= '0;
      dps       <= '0;
      valid     <= 1'b0;
      frame_stb <= 1'b0;
      err_seg   <= 1'b0;
      err_an    <= 1'b0;
    end else begin
      frame_stb <= 1'b0;
      if (chg) begin
        p     <= {an, seg, dp};
        cnt   <= '0;
        state <= SETTLING;
      end else if (cap) state <= HELD;
      else if (state == SETTLING) cnt <= cnt + 8'd1;
      // blank digits count toward the frame but keep their old nibble and dp
      if (good && known) begin
        digits[{idx, 2'b00} +: 4] <= nib;
        dps[idx]                  <= ~p[0];
      end
      if (clear) begin
        seen    <= '0;
        valid   <= 1'b0;
        err_seg <= 1'b0;
        err_an  <= 1'b0;
      end else begin
        if (cap && one && !known && !blank_seg) err_seg <= 1'b1;
        if (cap && !one && !blank_an) err_an <= 1'b1;
        if (seen_nxt == 4'hF) begin
          seen      <= '0;
          valid     <= 1'b1;
          frame_stb <= 1'b1;
        end else seen <= seen_nxt;
      end
    end
  end
endmodule

// File: tb/tb_sseg_capture.sv
// tb_sseg_capture: scenario tasks drive scan patterns; a run-length model predicts frames into a
// scoreboard queue that is popped whenever the DUT strobes frame_stb.
module tb_sseg_capture;
  localparam int SETTLE = 4;
  logic        clk = 1'b0, rst_n = 1'b0, dp = 1'b1, clear = 1'b0;
  logic [3:0]  an = 4'hF;
  logic [6:0]  seg = 7'h7F;
  logic [15:0] digits;
  logic [3:0]  dps;
  logic        valid, frame_stb, err_seg, err_an;
  typedef struct packed {logic [15:0] d; logic [3:0] p;} frame_t;
  frame_t      sb[$];
  int          checks = 0, fails = 0, nstb = 0;
  logic [15:0] m_dig;
  logic [3:0]  m_dps, m_seen;
  logic        m_valid, m_es, m_ea;
  logic [11:0] m_cur;
  int          m_run;
  logic [6:0]  glyph[16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                             7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  sseg_capture #(.SETTLE(SETTLE)) dut (
    .clk(clk), .rst_n(rst_n), .an(an), .seg(seg), .dp(dp), .clear(clear),
    .digits(digits), .dps(dps), .valid(valid), .frame_stb(frame_stb),
    .err_seg(err_seg), .err_an(err_an)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_dig = '0; m_dps = '0; m_seen = '0; m_valid = 0; m_es = 0; m_ea = 0;
    m_cur = 12'hFFF; m_run = SETTLE + 2;
  endtask

  // a pattern is taken once it has been present for SETTLE+1 consecutive edges
  task automatic step();
    int zeros, pos, hit;
    logic [11:0] pat;
    logic stb;
    pat = {an, seg, dp};
    stb = 0;
    m_run = (pat == m_cur) ? m_run + 1 : 1;
    m_cur = pat;
    if (m_run == SETTLE + 1) begin
      zeros = 0; pos = 0; hit = -1;
      for (int i = 0; i < 4; i++) if (!an[i]) begin zeros++; pos = i; end
      for (int g = 0; g < 16; g++) if (glyph[g] == seg) hit = g;
      if (zeros >= 2) m_ea = 1;
      else if (zeros == 1) begin
        if (hit >= 0) begin
          m_dig[pos*4 +: 4] = 4'(hit);
          m_dps[pos] = ~dp;
          m_seen[pos] = 1;
        end
`ifdef SSEG_CAP_BLANK_EN
        else if (seg == 7'h7F) m_seen[pos] = 1;
`endif
        else m_es = 1;
      end
      if (m_seen == 4'hF) begin stb = 1; m_valid = 1; m_seen = 0; end
    end
    if (clear) begin m_seen = 0; m_valid = 0; m_es = 0; m_ea = 0; stb = 0; end
    if (stb) sb.push_back({m_dig, m_dps});
  endtask

  task automatic hold(input logic [3:0] a, input logic [6:0] s, input logic d, input int n, input logic clr);
    frame_t f;
    an = a; seg = s; dp = d; clear = clr;
    repeat (n) begin
      @(posedge clk);
      step();
      @(negedge clk);
      if (frame_stb) begin
        nstb++;
        checks++;
        if (sb.size() == 0) begin
          fails++;
          $display("FAIL frame_stb: strobe seen with digits=%h, expected no strobe", digits);
        end else begin
          f = sb.pop_front();
          if (digits !== f.d || dps !== f.p || valid !== 1'b1) begin
            fails++;
            $display("FAIL frame: got digits=%h dps=%h valid=%b, expected digits=%h dps=%h valid=1", digits, dps, valid, f.d, f.p);
          end
        end
      end
    end
    clear = 0;
  endtask

  task automatic test_reset();
    model_reset();
    repeat (3) @(negedge clk);
    checks++; if ({digits, dps, valid, frame_stb, err_seg, err_an} !== 24'h0) begin fails++; $display("FAIL reset: got %h, expected 000000", {digits, dps, valid, frame_stb, err_seg, err_an}); end
    rst_n = 1;
  endtask

  task automatic test_latency();
    hold(4'hE, 7'h79, 1, 4, 0);
    hold(4'hF, 7'h7F, 1, 3, 0);
    checks++; if (digits !== 16'h0000) begin fails++; $display("FAIL glitch: got digits=%h, expected 0000", digits); end
    checks++; if (err_seg !== 1'b0) begin fails++; $display("FAIL glitch_err: got err_seg=%b, expected 0", err_seg); end
    hold(4'hE, 7'h79, 1, 4, 0);
    checks++; if (digits[3:0] !== 4'h0) begin fails++; $display("FAIL early: got nibble=%h after SETTLE edges, expected 0", digits[3:0]); end
    hold(4'hE, 7'h79, 1, 1, 0);
    checks++; if (digits[3:0] !== 4'h1) begin fails++; $display("FAIL latency: got nibble=%h after SETTLE+1 edges, expected 1", digits[3:0]); end
  endtask

  task automatic test_basic();
    int s0;
    s0 = nstb;
    hold(4'hE, 7'h03, 1, 8, 0);
    hold(4'hD, 7'h08, 1, 8, 0);
    hold(4'hB, 7'h21, 1, 8, 0);
    checks++; if (nstb !== s0) begin fails++; $display("FAIL early_stb: got %0d strobes before digit 3, expected 0", nstb - s0); end
    hold(4'h7, 7'h46, 1, 8, 0);
    checks++; if (nstb !== s0 + 1) begin fails++; $display("FAIL stb_count: got %0d strobes, expected 1", nstb - s0); end
    checks++; if (digits !== 16'hCDAB) begin fails++; $display("FAIL basic_digits: got %h, expected CDAB", digits); end
    checks++; if (dps !== 4'h0) begin fails++; $display("FAIL basic_dps: got %h, expected 0", dps); end
    checks++; if (valid !== 1'b1) begin fails++; $display("FAIL basic_valid: got %b, expected 1", valid); end
    checks++; if (frame_stb !== 1'b0) begin fails++; $display("FAIL stb_width: got frame_stb=%b cycles after capture, expected 0", frame_stb); end
  endtask

  task automatic test_dp_overwrite();
    int s0;
    hold(4'hD, 7'h02, 0, 8, 0);
    checks++; if (digits[7:4] !== 4'h6) begin fails++; $display("FAIL dp_digit: got %h, expected 6", digits[7:4]); end
    checks++; if (dps !== 4'b0010) begin fails++; $display("FAIL dp_lit: got dps=%b, expected 0010", dps); end
    s0 = nstb;
    hold(4'hF, 7'h7F, 1, 2, 0);
    hold(4'hD, 7'h78, 1, 8, 0);
    checks++; if (digits !== 16'hCD7B) begin fails++; $display("FAIL overwrite: got %h, expected CD7B", digits); end
    checks++; if (nstb !== s0) begin fails++; $display("FAIL overwrite_stb: got %0d strobes, expected 0", nstb - s0); end
  endtask

  task automatic test_errors();
    hold(4'hC, 7'h40, 1, 10, 0);
    checks++; if (err_an !== 1'b1) begin fails++; $display("FAIL err_an: got %b, expected 1", err_an); end
    checks++; if (digits !== m_dig) begin fails++; $display("FAIL err_an_digits: got %h, expected %h", digits, m_dig); end
    hold(4'hE, 7'h7E, 1, 8, 0);
    checks++; if (err_seg !== 1'b1) begin fails++; $display("FAIL err_seg: got %b, expected 1", err_seg); end
    hold(4'hE, 7'h7E, 1, 1, 1);
    checks++; if ({err_seg, err_an, valid} !== 3'b000) begin fails++; $display("FAIL clear_flags: got err_seg/err_an/valid=%b, expected 000", {err_seg, err_an, valid}); end
    checks++; if (digits !== 16'hCD7B) begin fails++; $display("FAIL clear_digits: got %h, expected CD7B", digits); end
  endtask

  task automatic test_blank_gaps();
    int s0;
    s0 = nstb;
    hold(4'hE, 7'h30, 1, 6, 0);
    hold(4'hF, 7'h7F, 1, 2, 0);
    hold(4'hD, 7'h12, 1, 6, 0);
    hold(4'hF, 7'h7F, 1, 20, 0);
    hold(4'hB, 7'h10, 0, 6, 0);
    checks++; if (nstb !== s0) begin fails++; $display("FAIL gap_early: got %0d strobes after 3 digits, expected 0", nstb - s0); end
    hold(4'hF, 7'h7F, 1, 2, 0);
    hold(4'h7, 7'h0E, 1, 6, 0);
    checks++; if (nstb !== s0 + 1) begin fails++; $display("FAIL gap_stb: got %0d strobes, expected 1", nstb - s0); end
    checks++; if ({err_seg, err_an} !== 2'b00) begin fails++; $display("FAIL gap_err: got %b, expected 00", {err_seg, err_an}); end
    checks++; if (digits !== 16'hF953 || dps !== 4'b0100) begin fails++; $display("FAIL gap_frame: got %h/%b, expected F953/0100", digits, dps); end
  endtask

  task automatic test_reset_mid();
    int s0;
    hold(4'hE, 7'h40, 1, 8, 0);
    hold(4'hF, 7'h7F, 1, 2, 0);
    hold(4'hD, 7'h79, 1, 8, 0);
    hold(4'hB, 7'h24, 1, 2, 0);
    #2 rst_n = 0;
    #1;
    checks++; if ({digits, dps, valid, frame_stb, err_seg, err_an} !== 24'h0) begin fails++; $display("FAIL mid_reset: got %h, expected 000000", {digits, dps, valid, frame_stb, err_seg, err_an}); end
    an = 4'hF; seg = 7'h7F; dp = 1;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1;
    s0 = nstb;
    hold(4'hE, 7'h40, 1, 8, 0);
    hold(4'hD, 7'h79, 1, 8, 0);
    hold(4'hB, 7'h24, 1, 8, 0);
    checks++; if (nstb !== s0) begin fails++; $display("FAIL post_reset_early: got %0d strobes after 3 digits, expected 0", nstb - s0); end
    hold(4'h7, 7'h30, 1, 8, 0);
    checks++; if (nstb !== s0 + 1 || digits !== 16'h3210) begin fails++; $display("FAIL post_reset_frame: got %0d strobes digits=%h, expected 1 and 3210", nstb - s0, digits); end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_basic();
    test_dp_overwrite();
    test_errors();
    test_blank_gaps();
    test_reset_mid();
    checks++; if (sb.size() != 0) begin fails++; $display("FAIL missing_stb: got %0d unmatched predicted frames, expected 0", sb.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/sseg_capture.md
# sseg_capture

Seven-segment scan capture: the receive end of the four-digit seven-segment display interface (an/seg/dp) driven by our display blocks. It watches the multiplexed anode/segment/dp lines, waits for each scanned pattern to settle, decodes the glyph back to a hex nibble and assembles the four digits into a 16-bit word. It sits in self-check and loopback builds beside the display driver, so the displayed value can be compared against the value the driver was given.

## Interface
- `SETTLE`, default 4: cycles a pattern must hold before capture; legal range 1..255.
- `clk  input  1`: single clock; all state changes on its rising edge.
- `rst_n  input  1`: asynchronous, active-low reset.
- `an  input  4`: anode enables, active-low; `an[i]=0` selects digit i, with digit 0 rightmost.
- `seg  input  7`: segments, active-low; `seg[0]`=a … `seg[6]`=g.
- `dp  input  1`: decimal point, active-low.
- `clear  input  1`: synchronous clear of the frame mask and sticky errors.
- `digits  output  16`: captured nibbles; `digits[4i+3:4i]` holds digit i.
- `dps  output  4`: captured decimal points, active-high; `dps[i]=1` means the dp was lit.
- `valid  output  1`: all four digits captured at least once since reset or clear.
- `frame_stb  output  1`: one-cycle pulse marking completion of a scan frame.
- `err_seg  output  1`: sticky flag for an undecodable glyph.
- `err_an  output  1`: sticky flag for an illegal anode pattern.

## Operation
- **Glyph table** (seg[6:0], hex): 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E.
- **Pattern register:**
  - The block holds a register P = {an, seg, dp} plus a settle counter `cnt` and an `armed` bit.
  - Each edge where the input differs from P: load P, set `cnt`=0, set `armed`=1.
  - Otherwise, if `armed` and `cnt`==SETTLE-1, evaluate P (this is the "capture") and clear `armed`.
  - Otherwise, if `armed`, increment `cnt`.
- **States:**
  - IDLE: `armed`=0, no capture pending.
  - SETTLING: `armed`=1.
  - HELD: captured; waits for the next input change.
  - Transitions: any input change goes to SETTLING; the counter reaching its limit goes to HELD.
- **Evaluating P at capture:**
  - `an`=4'b1111 (blanking gap): no action, no error.
  - `an` with exactly one zero at bit i, seg in the table: write the nibble to digit i, write `dps[i]`=~dp, and set `seen[i]`.
  - `an` with exactly one zero, seg not in the table: set `err_seg`; digit i and `seen[i]` are unchanged.
  - `an` with two or more zeros: set `err_an`; nothing else changes.
- **Frame completion:**
  - When a capture makes `seen` equal to 4'b1111, pulse `frame_stb` and set `valid`.
  - `seen` clears on that same edge.
  - Capturing the same digit again within a frame overwrites it and does not advance `seen`.
- **Clear:** `clear`=1 zeroes `seen`, `valid`, `err_seg` and `err_an`, and suppresses that cycle's `frame_stb`. `digits` and `dps` are retained.
- **Simultaneous capture and clear:** clear wins for flags and `seen`; the digit write still happens.

## Timing
- Reset values:
  - `digits`=16'h0000, `dps`=4'h0.
  - `valid`, `frame_stb`, `err_seg` and `err_an` all 0.
  - P=all ones, `cnt`=0, `armed`=0, `seen`=0.
- **Capture latency:** a pattern first present before edge k is loaded at edge k. If it stays stable through edge k+SETTLE, it is captured at edge k+SETTLE. Outputs are valid after that edge, so the pattern must hold for SETTLE+1 edges.
- **Ghosting:** a pattern shorter than SETTLE+1 edges is never captured and raises no error.
- **Input change on the capture edge:** the change wins; the new pattern loads and the old one is discarded.
- `frame_stb` is high for exactly the one cycle after the completing capture edge.
- **Asynchronous reset mid-settle:** reset aborts the settle; no partial digit write.
- All outputs are registered; there is no combinational input-to-output path.

## Configuration
- **`SSEG_CAP_BLANK_EN` defined:** seg=7F (all segments off) with exactly one anode low is accepted as a blank digit. Blank digits:
  - leave the nibble unchanged;
  - set `seen[i]`;
  - do not raise `err_seg`.
- **`SSEG_CAP_BLANK_EN` undefined:** seg=7F is treated as undecodable and raises `err_seg`.

## Test plan
- **Basic scan:** SETTLE=4; scan an=E,D,B,7 with glyphs for B,A,D,C, each held 8 cycles, dp off. Required response: `digits`=16'hCDAB, `dps`=0, `frame_stb` is a single pulse after digit 3's capture, and `valid`=1.
- **Latency and glitch:** hold an=E/seg=79 for exactly 4 edges, so it is not captured and `digits` stays 0. Then hold it for 5 edges: `digits[3:0]`=1 after edge k+4.
- **Decimal point and overwrite:** an=D, seg=02, dp=0 gives `digits[7:4]`=6 and `dps[1]`=1. Re-scanning digit 1 with seg=78 gives nibble 7 with no `frame_stb`.
- **Errors:**
  - an=C for 10 cycles raises `err_an`, and `digits` is unchanged.
  - an=E with seg=7E raises `err_seg` (with the macro off).
  - `clear`=1 drops both flags and `valid`; `digits` is retained.
- **Blank gaps:** insert an=F gaps of 2 and of 20 cycles between digits; no errors result and the frame completes normally.
- **Reset mid-operation:** assert `rst_n`=0 while in SETTLING with 2 digits seen; all outputs return to their reset values. A full scan after release yields `frame_stb` only after all four digits are captured.
